// File: rtl/bram_pkg.sv
// Shared types and helpers for the BRAM port controller.
package bram_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = DATA_W / 8;
  // The merge helper works on a wide fixed vector so any data width up to this size can reuse it.
  localparam int unsigned MERGE_BE = 8 * BE_W;
  localparam int unsigned MERGE_W  = 8 * MERGE_BE;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } bram_state_e;

  // Byte-wise select: strobed bytes come from new_d, the rest from old_d.
  function automatic logic [MERGE_W-1:0] merge_bytes(input logic [MERGE_W-1:0]  old_d,
                                                     input logic [MERGE_W-1:0]  new_d,
                                                     input logic [MERGE_BE-1:0] be);
    logic [MERGE_W-1:0] res;
    res = '0;
    for (int k = 0; k < int'(MERGE_BE); k++) begin
      res[k*8 +: 8] = be[k] ? new_d[k*8 +: 8] : old_d[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Small response FIFO: registered storage, head word presented directly on rd_data.
module bram_rsp_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop & (count_q != '0);
  assign push_ok = push & (~full | pop_ok);

  assign valid   = (count_q != '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= next_ptr(rd_ptr_q);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bram_port_ctrl.sv
// Initiator-side controller for one BRAM port: reads, full writes and byte-masked RMW writes.
module bram_port_ctrl
  import bram_pkg::*;
#(
  parameter  int unsigned WIDTH     = DATA_W,
  parameter  int unsigned DEPTH     = 32,
  parameter  int unsigned RSP_DEPTH = 2,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned BW        = WIDTH / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [BW-1:0]    req_be,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_din,
  input  logic [WIDTH-1:0] mem_dout
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  bram_state_e      state_q;
  bram_state_e      state_d;
  logic [AW-1:0]    addr_q;
  logic [BW-1:0]    be_q;
  logic [WIDTH-1:0] wdata_q;
  logic             inflight_q;
  logic             rd_issue;
  logic             rmw_latch;
  logic             accept;
  logic             pop;
  logic [CW-1:0]    rsp_count;
  logic [SW-1:0]    credit_sum;
  logic             rd_credit;
  logic             be_full;
  logic             be_none;

  assign pop        = rsp_valid & rsp_ready;
  assign be_full    = &req_be;
  assign be_none    = ~|req_be;
  // Reads in flight plus queued responses, net of this cycle's pop, must fit in the FIFO.
  assign credit_sum = SW'(rsp_count) + SW'(inflight_q) - SW'(pop);
  assign rd_credit  = (credit_sum < SW'(RSP_DEPTH));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshake and BRAM port drive.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_din   = '0;
    rd_issue  = 1'b0;
    rmw_latch = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reset) req_ready = req_we ? 1'b1 : rd_credit;
        accept = req_valid & req_ready;
        if (accept) begin
          if (!req_we) begin
            mem_addr = req_addr;
            rd_issue = 1'b1;
          end else if (be_full) begin
            mem_addr = req_addr;
            mem_we   = 1'b1;
            mem_din  = req_wdata;
          end else if (!be_none) begin
            // Partial write: fetch the old word, merge it next cycle.
            mem_addr  = req_addr;
            rmw_latch = 1'b1;
            state_d   = MERGE;
          end
        end
      end
      MERGE: begin
        mem_addr = addr_q;
        mem_we   = 1'b1;
        mem_din  = WIDTH'(merge_bytes(MERGE_W'(mem_dout), MERGE_W'(wdata_q), MERGE_BE'(be_q)));
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-in-flight flag and RMW request capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
    end else begin
      inflight_q <= rd_issue;
      if (rmw_latch) begin
        addr_q  <= req_addr;
        be_q    <= req_be;
        wdata_q <= req_wdata;
      end
    end
  end

  // Read data lands one cycle after issue and is queued for the consumer.
  bram_rsp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (mem_dout),
    .pop       (pop),
    .rd_data   (rsp_rdata),
    .valid     (rsp_valid),
    .count     (rsp_count)
  );

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Self-checking bench for bram_port_ctrl: BRAM model, shadow memory and response scoreboard.
module tb_bram_port_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned RD = 2;
  localparam int unsigned AW = 5;
  localparam int unsigned BW = 4;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_be;
  logic [W-1:0]  req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [W-1:0]  mem_din;
  logic [W-1:0]  mem_dout;
  logic          preload;

  logic [W-1:0]  bram   [D];
  logic [W-1:0]  shadow [D];
  logic [W-1:0]  exp_q  [$];

  int            n_checks;
  int            n_errors;
  logic          last_acc;
  logic          last_pop;
  logic [W-1:0]  last_rdata;
  logic          merge_pending;
  logic          prev_hold;
  logic [W-1:0]  prev_rdata;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [W-1:0]  wdata;
    logic [W-1:0]  exp_rdata;
    int            exp_stall;
  } vec_t;

  vec_t tv [14];

  bram_port_ctrl #(.WIDTH(W), .DEPTH(D), .RSP_DEPTH(RD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: registered dout, read-before-write.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < int'(D); i++) bram[i] <= 32'hA000_0000 | W'(i);
      mem_dout <= '0;
    end else begin
      mem_dout <= bram[mem_addr];
      if (mem_we) bram[mem_addr] <= mem_din;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock of the request/response protocol, starting from a falling edge with inputs driven.
  task automatic cycle();
    int   outs;
    logic exp_rdy;
    logic exp_we;
    #1;
    last_acc   = req_valid && req_ready;
    last_pop   = rsp_valid && rsp_ready;
    last_rdata = rsp_rdata;
    outs       = exp_q.size();
    if (merge_pending)  exp_rdy = 1'b0;
    else if (req_we)    exp_rdy = 1'b1;
    else                exp_rdy = ((outs - int'(last_pop)) < int'(RD));
    chk("req_ready", W'(req_ready), W'(exp_rdy));
    exp_we = merge_pending || (last_acc && req_we && (req_be == 4'hF));
    chk("mem_we", W'(mem_we), W'(exp_we));
    if (prev_hold) begin
      chk("rsp_valid hold", W'(rsp_valid), 32'd1);
      chk("rsp_rdata hold", rsp_rdata, prev_rdata);
    end
    prev_hold  = rsp_valid && !rsp_ready;
    prev_rdata = rsp_rdata;
    if (last_pop) begin
      if (exp_q.size() == 0) chk("rsp_valid unexpected", W'(rsp_valid), 32'd0);
      else                   chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
    end
    merge_pending = 1'b0;
    if (last_acc) begin
      if (!req_we) exp_q.push_back(shadow[req_addr]);
      else begin
        for (int k = 0; k < int'(BW); k++)
          if (req_be[k]) shadow[req_addr][k*8 +: 8] = req_wdata[k*8 +: 8];
        merge_pending = (req_be != 4'h0) && (req_be != 4'hF);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk($sformatf("%s req_ready", tag), W'(req_ready), 32'd0);
    chk($sformatf("%s rsp_valid", tag), W'(rsp_valid), 32'd0);
    chk($sformatf("%s mem_we", tag),    W'(mem_we),    32'd0);
    chk($sformatf("%s mem_addr", tag),  W'(mem_addr),  32'd0);
    chk($sformatf("%s mem_din", tag),   mem_din,       32'd0);
  endtask

  task automatic apply_vec(input vec_t v, input string nm);
    int stall;
    int lat;
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_be    = v.be;
    req_wdata = v.wdata;
    stall = 0;
    cycle();
    while (!last_acc && stall < 8) begin
      stall++;
      cycle();
    end
    chk($sformatf("%s accepted", nm), W'(last_acc), 32'd1);
    chk($sformatf("%s stall", nm), W'(stall), W'(v.exp_stall));
    req_valid = 1'b0;
    if (!v.we) begin
      lat = 0;
      do begin
        cycle();
        lat++;
      end while (!last_pop && lat < 8);
      chk($sformatf("%s latency", nm), W'(lat), 32'd2);
      chk($sformatf("%s rdata", nm), last_rdata, v.exp_rdata);
    end
  endtask

  task automatic drain(input string nm);
    int g;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    g = 0;
    while ((exp_q.size() > 0 || merge_pending) && g < 50) begin
      cycle();
      g++;
    end
    chk($sformatf("%s drained", nm), W'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int   idx;
    int   pops;
    int   g;
    int   bubbles;
    vec_t rv;
    logic [W-1:0] saved;

    n_checks = 0;  n_errors = 0;
    last_acc = 0;  last_pop = 0;  last_rdata = '0;
    merge_pending = 0;  prev_hold = 0;  prev_rdata = '0;
    reset = 1'b0;  preload = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_be = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(D); i++) shadow[i] = 32'hA000_0000 | W'(i);

    tv[0]  = '{we:1'b1, addr:5'd5,  be:4'hF, wdata:32'hDEADBEEF, exp_rdata:32'h0,        exp_stall:0};
    tv[1]  = '{we:1'b0, addr:5'd5,  be:4'h0, wdata:32'h0,        exp_rdata:32'hDEADBEEF, exp_stall:0};
    tv[2]  = '{we:1'b1, addr:5'd3,  be:4'hF, wdata:32'h11223344, exp_rdata:32'h0,        exp_stall:0};
    tv[3]  = '{we:1'b1, addr:5'd3,  be:4'h5, wdata:32'hAABBCCDD, exp_rdata:32'h0,        exp_stall:0};
    tv[4]  = '{we:1'b0, addr:5'd3,  be:4'h0, wdata:32'h0,        exp_rdata:32'h11BB33DD, exp_stall:1};
    tv[5]  = '{we:1'b1, addr:5'd7,  be:4'h0, wdata:32'h55555555, exp_rdata:32'h0,        exp_stall:0};
    tv[6]  = '{we:1'b0, addr:5'd7,  be:4'h0, wdata:32'h0,        exp_rdata:32'hA0000007, exp_stall:0};
    tv[7]  = '{we:1'b1, addr:5'd31, be:4'hF, wdata:32'hCAFEF00D, exp_rdata:32'h0,        exp_stall:0};
    tv[8]  = '{we:1'b0, addr:5'd31, be:4'h0, wdata:32'h0,        exp_rdata:32'hCAFEF00D, exp_stall:0};
    tv[9]  = '{we:1'b0, addr:5'd0,  be:4'h0, wdata:32'h0,        exp_rdata:32'hA0000000, exp_stall:0};
    tv[10] = '{we:1'b1, addr:5'd0,  be:4'h8, wdata:32'h77123456, exp_rdata:32'h0,        exp_stall:0};
    tv[11] = '{we:1'b0, addr:5'd0,  be:4'h0, wdata:32'h0,        exp_rdata:32'h77000000, exp_stall:1};
    tv[12] = '{we:1'b1, addr:5'd31, be:4'h3, wdata:32'h12345678, exp_rdata:32'h0,        exp_stall:0};
    tv[13] = '{we:1'b0, addr:5'd31, be:4'h0, wdata:32'h0,        exp_rdata:32'hCAFE5678, exp_stall:1};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    preload = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 14; i++) apply_vec(tv[i], $sformatf("vec%0d", i));

    // Backpressure: only the FIFO depth worth of reads may be taken.
    rsp_ready = 1'b0;
    idx = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
    repeat (6) begin
      cycle();
      if (last_acc) begin idx++; req_addr = AW'(idx); end
    end
    chk("bp accepted while stalled", W'(idx), 32'd2);
    rsp_ready = 1'b1;
    pops = 0;  g = 0;
    while (idx < 4 && g < 20) begin
      cycle();
      if (last_acc) begin idx++; req_addr = AW'(idx); end
      if (last_pop) pops++;
      g++;
    end
    req_valid = 1'b0;
    while (exp_q.size() > 0 && g < 40) begin
      cycle();
      if (last_pop) pops++;
      g++;
    end
    chk("bp responses", W'(pops), 32'd4);

    // Streaming: one read per cycle with the consumer always ready.
    bubbles = 0;  pops = 0;
    req_valid = 1'b1; req_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req_addr = AW'(8 + k);
      cycle();
      if (!last_acc) bubbles++;
      if (last_pop) pops++;
    end
    req_valid = 1'b0;
    g = 0;
    while (exp_q.size() > 0 && g < 20) begin
      cycle();
      if (last_pop) pops++;
      g++;
    end
    chk("stream bubbles", W'(bubbles), 32'd0);
    chk("stream responses", W'(pops), 32'd8);

    // Reset while the merge write is on the port.
    saved = shadow[9];
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd9; req_be = 4'h3; req_wdata = 32'hFFFFFFFF;
    cycle();
    chk("rmw accepted", W'(last_acc), 32'd1);
    req_valid = 1'b0;
    #1;
    chk("merge mem_we live", W'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset in merge");
    shadow[9] = saved;
    exp_q.delete();
    merge_pending = 1'b0;
    prev_hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    rv = '{we:1'b0, addr:5'd9, be:4'h0, wdata:32'h0, exp_rdata:32'hA0000009, exp_stall:0};
    apply_vec(rv, "read after aborted rmw");

    // Random traffic against the shadow memory and response queue.
    req_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!req_valid || last_acc) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom_range(0, D - 1));
        case ($urandom_range(0, 3))
          0:       req_be = 4'hF;
          1:       req_be = 4'h0;
          default: req_be = 4'($urandom_range(0, 15));
        endcase
        req_wdata = $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain("random");
    cycle();

    for (int i = 0; i < int'(D); i++) chk($sformatf("mem[%0d]", i), bram[i], shadow[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
